// File: rtl/mx_scan.sv
// mx_scan: registered channel mux, direct or masked
// round-robin scan select, valid/ready output slot.
module mx_scan #(
  parameter int N = 2,
  parameter int B = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<N)*B-1:0]   x,
  input  logic [N-1:0]          a,
  input  logic                  mode,
  input  logic [(1<<N)-1:0]     m,
  input  logic                  en,
  input  logic                  rdy,
  output logic [B-1:0]          y,
  output logic [N-1:0]          sel,
  output logic                  v,
  output logic                  wrap
);

  localparam int C = 1 << N;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] LAST = N'(C - 1);

  logic [N-1:0] p;
  logic [N-1:0] c;
  logic         hit;
  logic         free;
  logic         xfer;
  logic         cap;
  logic         drain;
  logic [N-1:0] idx;
  logic [B-1:0] grp;
  logic         cwrap;

  // first masked-in channel at or after p, circularly
  always_comb begin
    hit = 1'b0;
    c   = '0;
    for (int i = 0; i < C; i++) begin
      if (!hit && m[p + N'(i)]) begin
        hit = 1'b1;
        c   = p + N'(i);
      end
    end
  end

  assign free  = !v || rdy;
  assign xfer  = v && rdy;
  assign cap   = en && free && (!mode || hit);
  assign drain = xfer && !cap;
  assign idx   = mode ? c : a;
  assign grp   = x[idx*B +: B];

  // a scan pass completes when the search wraps
  // past the top channel or lands on it
  assign cwrap = mode && ((c < p) || (c == LAST));

  // output slot: capture, drain on transfer, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      sel  <= '0;
      v    <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (1'b1)
        cap: begin
          y    <= grp;
          sel  <= idx;
          v    <= 1'b1;
          wrap <= cwrap;
        end
        drain: begin
          v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // scan pointer moves just past each scan capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (cap && mode) begin
      p <= c + ONE;
    end
  end

endmodule

// File: tb/tb_mx_scan.sv
// tb_mx_scan: directed plan plus random stimulus
// against a list-based reference of the scan rules.
module tb_mx_scan;

  localparam int N = 2;
  localparam int B = 2;
  localparam int C = 1 << N;
  localparam logic [C*B-1:0] XR = 8'b11_10_01_00;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C*B-1:0] x;
  logic [N-1:0]   a;
  logic           mode;
  logic [C-1:0]   m;
  logic           en;
  logic           rdy;
  logic [B-1:0]   y;
  logic [N-1:0]   sel;
  logic           v;
  logic           wrap;

  int checks   = 0;
  int failures = 0;

  int ry, rsel, rv, rwrap, rp;

  mx_scan #(.N(N), .B(B)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .a    (a),
    .mode (mode),
    .m    (m),
    .en   (en),
    .rdy  (rdy),
    .y    (y),
    .sel  (sel),
    .v    (v),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int grpof(input int k);
    return int'((x >> (k * B)) & ((1 << B) - 1));
  endfunction

  task automatic model_reset();
    ry = 0; rsel = 0; rv = 0; rwrap = 0; rp = 0;
  endtask

  // enabled channels as a list; take the smallest at or
  // above the pointer, else the smallest overall
  task automatic model_step();
    int c;
    int lst[$];
    bit cap;
    cap = en && (!rv || rdy) && (!mode || m != 0);
    if (cap) begin
      if (!mode) begin
        c = a;
        rwrap = 0;
      end else begin
        for (int k = 0; k < C; k++)
          if (m[k]) lst.push_back(k);
        c = lst[0];
        foreach (lst[j])
          if (lst[j] >= rp) begin
            c = lst[j];
            break;
          end
        rwrap = (c < rp || c == C - 1) ? 1 : 0;
        rp = (c + 1) % C;
      end
      ry = grpof(c);
      rsel = c;
      rv = 1;
    end else begin
      if (rv && rdy) rv = 0;
      rwrap = 0;
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".y"},    32'(y),    32'(ry));
    chk({tag, ".sel"},  32'(sel),  32'(rsel));
    chk({tag, ".v"},    32'(v),    32'(rv));
    chk({tag, ".wrap"}, 32'(wrap), 32'(rwrap));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    x = XR; a = '0; mode = 1'b0; m = '0;
    en = 1'b0; rdy = 1'b0;
    model_reset();
    #12;
    chk("rst.y",    32'(y),    0);
    chk("rst.sel",  32'(sel),  0);
    chk("rst.v",    32'(v),    0);
    chk("rst.wrap", 32'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // direct mode
    mode = 1'b0; a = 2'd2; en = 1'b1; rdy = 1'b1;
    cyc("dir");
    chk("dir.yc",   32'(y),   2);
    chk("dir.selc", 32'(sel), 2);
    en = 1'b0;
    cyc("dir2");
    chk("dir2.vc", 32'(v), 0);
    chk("dir2.yc", 32'(y), 2);

    // full scan
    mode = 1'b1; m = 4'b1111; en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc("scan");
      chk("scan.selc", 32'(sel), 32'(i % 4));
      chk("scan.wrapc", 32'(wrap), (i % 4 == 3) ? 1 : 0);
    end

    // masked scan then empty mask
    m = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc("mask");
      chk("mask.selc", 32'(sel), (i % 2 == 0) ? 0 : 2);
    end
    m = 4'b0000;
    for (int i = 0; i < 3; i++) cyc("mzero");
    chk("mzero.vc", 32'(v), 0);

    // backpressure
    mode = 1'b0; a = 2'd1; m = 4'b1111;
    cyc("bp0");
    chk("bp0.yc", 32'(y), 1);
    mode = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = ~x;
      cyc("bp");
      chk("bp.yc", 32'(y), 1);
    end
    x = XR; rdy = 1'b1;
    cyc("bp1");

    // mode interleave
    for (int i = 0; i < 2; i++) cyc("mi.s");
    mode = 1'b0; a = 2'd0;
    for (int i = 0; i < 2; i++) cyc("mi.d");
    mode = 1'b1;
    cyc("mi.r");

    // reset mid-scan
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    m = 4'b1111;
    for (int i = 0; i < 3; i++) cyc("pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst.y",    32'(y),    0);
    chk("mrst.sel",  32'(sel),  0);
    chk("mrst.v",    32'(v),    0);
    chk("mrst.wrap", 32'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post");
    chk("post.selc", 32'(sel), 0);

    // random
    for (int i = 0; i < 400; i++) begin
      x = C*B'($urandom);
      a = N'($urandom);
      mode = 1'($urandom);
      m = C'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      en = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
